// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit that owns the HI/LO registers.
// Optional MDU_FAST_MUL_EN: single-cycle combinational MULT/MULTU; division stays iterative.
module mul_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [4:0]       alucontrol,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q;
   logic             is_div_q, neg_q, rneg_q;
   logic [WIDTH-1:0] acc_q, low_q, opd_q;
   logic [WIDTH-1:0] acc_d, low_d;

   logic             go, is_mul, is_div, is_mthi, is_mtlo, signed_op, slow_op;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted, diff, sum;
   logic [2*WIDTH-1:0] prod_mag, prod_res;
   logic [WIDTH-1:0] q_res, r_res;
`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_mag, fast_res;
`endif

   always_comb begin
      go        = start & ~flush;
      is_mul    = (alucontrol[4:1] == 4'b1000);
      is_div    = (alucontrol[4:1] == 4'b1001);
      is_mthi   = (alucontrol == 5'b10100);
      is_mtlo   = (alucontrol == 5'b10101);
      signed_op = ~alucontrol[0];
      a_neg     = signed_op & srca[WIDTH-1];
      b_neg     = signed_op & srcb[WIDTH-1];
      a_mag     = a_neg ? -srca : srca;
      b_mag     = b_neg ? -srcb : srcb;
`ifdef MDU_FAST_MUL_EN
      slow_op   = is_div;
      fast_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
      fast_res  = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`else
      slow_op   = is_div | is_mul;
`endif

      // acc holds the running remainder (div) or upper partial product (mul);
      // low holds the dividend/quotient or multiplier/lower product bits.
      shifted = {acc_q, low_q[WIDTH-1]};
      diff    = shifted - {1'b0, opd_q};
      sum     = {1'b0, acc_q} + (low_q[0] ? {1'b0, opd_q} : '0);
      if (is_div_q) begin
         acc_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
         low_d = {low_q[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
         {acc_d, low_d} = {sum, low_q[WIDTH-1:1]};
      end

      prod_mag = {acc_d, low_d};
      prod_res = neg_q ? -prod_mag : prod_mag;
      q_res    = neg_q ? -low_d : low_d;
      r_res    = rneg_q ? -acc_d : acc_d;

      stall = (state_q == S_RUN) || ((state_q == S_IDLE) && go && slow_op);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         acc_q    <= '0;
         low_q    <= '0;
         opd_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (go) begin
                  if (is_mthi) begin
                     hi_q <= srca;
                  end else if (is_mtlo) begin
                     lo_q <= srca;
`ifdef MDU_FAST_MUL_EN
                  end else if (is_mul) begin
                     {hi_q, lo_q} <= fast_res;
                     done_q       <= 1'b1;
`endif
                  end else if (slow_op) begin
                     state_q  <= S_RUN;
                     cnt_q    <= '0;
                     is_div_q <= is_div;
                     neg_q    <= a_neg ^ b_neg;
                     rneg_q   <= a_neg;
                     acc_q    <= '0;
                     low_q    <= a_mag;
                     opd_q    <= b_mag;
                  end
               end
            end
            S_RUN: begin
               if (flush) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else begin
                  acc_q <= acc_d;
                  low_q <= low_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     if (is_div_q) begin
                        hi_q <= r_res;
                        lo_q <= q_res;
                     end else begin
                        {hi_q, lo_q} <= prod_res;
                     end
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     cnt_q   <= '0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed mul/div/MTxx/flush/reset vectors.
module tb_mul_div_unit;

   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;
   localparam logic [4:0] OP_MTHI  = 5'b10100;
   localparam logic [4:0] OP_MTLO  = 5'b10101;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_STALLS = 0;
`else
   localparam int MUL_STALLS = 33;
`endif
   localparam int DIV_STALLS = 33;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  alucontrol = '0;
   logic [31:0] srca = '0;
   logic [31:0] srcb = '0;
   logic        flush = 1'b0;
   logic        stall, done;
   logic [31:0] hi, lo;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .resetn(resetn), .start(start), .alucontrol(alucontrol),
      .srca(srca), .srcb(srcb), .flush(flush),
      .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (resetn && done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_hi"}, {32'd0, hi}, {32'd0, mon_e.hi});
            chk({mon_e.name, "_lo"}, {32'd0, lo}, {32'd0, mon_e.lo});
         end
      end
   end

   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e,
                         input int exp_stalls);
      int   n;
      exp_t e;
      n = 0;
      e.name = name; e.hi = hi_e; e.lo = lo_e;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b1; alucontrol = op; srca = a; srcb = b;
      #1;
      while (stall && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk({name, "_stalls"}, 64'(n), 64'(exp_stalls));
      // start stays high through the done cycle; it must not relaunch the op
      @(negedge clk);
      start = 1'b0;
      #1;
      chk({name, "_stall_after"}, {63'd0, stall}, 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_stall", {63'd0, stall}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_STALLS);

      // Reset asserted ten cycles into a division
      @(negedge clk);
      start = 1'b1; alucontrol = OP_DIVU; srca = 32'd5; srcb = 32'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("midrst_hi", {32'd0, hi}, 64'd0);
      chk("midrst_lo", {32'd0, lo}, 64'd0);
      chk("midrst_stall", {63'd0, stall}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_STALLS);
      run_op("div_7_m2",    OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_STALLS);
      run_op("divu_by0",    OP_DIVU, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, DIV_STALLS);
      run_op("div_m5_by0",  OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'd1,         DIV_STALLS);
      run_op("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_STALLS);
      run_op("mult_m3_5",   OP_MULT, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_STALLS);
      run_op("multu_max_2", OP_MULTU,32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, MUL_STALLS);
      run_op("mult_m1_m1",  OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         MUL_STALLS);
      run_op("mult_big",    OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MUL_STALLS);

      // Unrelated code: no stall, no register change
      @(negedge clk);
      start = 1'b1; alucontrol = 5'b00010; srca = 32'hDEAD_BEEF;
      #1;
      chk("other_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      chk("other_hi", {32'd0, hi}, 64'h3FFF_FFFF);
      chk("other_lo", {32'd0, lo}, 64'h0000_0001);

      // MTHI then MTLO back to back
      start = 1'b1; alucontrol = OP_MTHI; srca = 32'hA5A5_A5A5;
      #1;
      chk("mthi_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      alucontrol = OP_MTLO; srca = 32'h5A5A_5A5A;
      #1;
      chk("mthi_hi", {32'd0, hi}, 64'hA5A5_A5A5);
      chk("mthi_lo_kept", {32'd0, lo}, 64'h0000_0001);
      chk("mtlo_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      chk("mtlo_lo", {32'd0, lo}, 64'h5A5A_5A5A);

      // Flush in IDLE suppresses MTHI and a division start
      @(negedge clk);
      start = 1'b1; alucontrol = OP_MTHI; srca = 32'h0; flush = 1'b1;
      #1;
      chk("iflush_mthi_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      alucontrol = OP_DIVU; srca = 32'd9; srcb = 32'd3;
      #1;
      chk("iflush_div_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      chk("iflush_hi", {32'd0, hi}, 64'hA5A5_A5A5);
      chk("iflush_stall_after", {63'd0, stall}, 64'd0);

      // Flush at RUN counter 5 of a DIVU
      @(negedge clk);
      start = 1'b1; alucontrol = OP_DIVU; srca = 32'd1000; srcb = 32'd3;
      repeat (6) @(negedge clk);
      start = 1'b0; flush = 1'b1;
      #1;
      chk("rflush_stall_same", {63'd0, stall}, 64'd1);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("rflush_stall_next", {63'd0, stall}, 64'd0);
      chk("rflush_hi", {32'd0, hi}, 64'hA5A5_A5A5);
      chk("rflush_lo", {32'd0, lo}, 64'h5A5A_5A5A);
      repeat (40) @(negedge clk);
      chk("rflush_hi_late", {32'd0, hi}, 64'hA5A5_A5A5);
      chk("rflush_lo_late", {32'd0, lo}, 64'h5A5A_5A5A);

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage multiply/divide unit. Sits directly downstream of the ALU decoder, next to the main ALU.
- Consumes the 5-bit alucontrol code plus both operands. Owns the architectural HI/LO registers.
- Runs iterative 32-cycle division, and multiplication that is iterative by default. Asserts a pipeline stall while busy.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous active-low reset
- start  in  1  EX stage holds a valid instruction with this alucontrol
- alucontrol  in  5  operation code (encodings in Behaviour)
- srca  in  WIDTH  rs operand; dividend; MTHI/MTLO source
- srcb  in  WIDTH  rt operand; divisor
- flush  in  1  kill in-flight operation (exception/branch flush)
- stall  out  1  hold IF/ID/EX stages
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Op encodings:
  - 5'b10000 MULT
  - 5'b10001 MULTU
  - 5'b10010 DIV
  - 5'b10011 DIVU
  - 5'b10100 MTHI
  - 5'b10101 MTLO
  - Any other code, or start=0: no effect.
- Reset (resetn=0 at clock edge): hi=0, lo=0, state=IDLE, counter=0, done=0. Reset overrides start and flush, and aborts any operation mid-flight.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start plus a mul/div code: latch operands, sign flags and op at the edge; counter=0; go to RUN.
  - stall is combinational: 1 in this cycle.
  - start plus MTHI/MTLO: hi (or lo) <= srca at the edge. Stay IDLE; stall=0.
- RUN:
  - One iteration per cycle; counter increments 0..WIDTH-1; stall=1.
  - On the edge where counter==WIDTH-1: write {hi,lo}, go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, stall=0. start is ignored, because the same instruction is still presented while it leaves EX.
  - Then go to IDLE.
- Latency, div and default mul:
  - start in cycle 0; stall=1 in cycles 0..WIDTH; done=1 and new hi/lo visible in cycle WIDTH+1.
  - That is 33 stall cycles for WIDTH=32.
- Multiply:
  - Shift-add over magnitudes; 2*WIDTH-bit product. hi=upper half, lo=lower half.
  - MULT negates the product when operand signs differ.
- Divide:
  - Restoring division on magnitudes.
  - DIV: quotient sign = sign(srca) XOR sign(srcb); remainder sign = sign(srca).
  - Result: lo=quotient, hi=remainder.
- Divide by zero (divisor latched as 0):
  - Runs the full latency; no exception.
  - Result: lo=all ones, hi=dividend (unsigned magnitude path).
  - For DIV, the sign correction is still applied.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. Wraps; no trap.
- Flush:
  - flush=1 in RUN or DONE: next state IDLE. hi/lo unchanged, done=0.
  - In IDLE, flush suppresses any start in the same cycle, including MTHI/MTLO.
  - stall deasserts in the cycle after flush.
- hi/lo change only at the final edge of an operation, at MTHI/MTLO, or at reset.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational multiplier; hi/lo written at the start edge.
  - No RUN/DONE, stall=0, done pulses the following cycle. Division is unchanged.
- Undefined: multiply uses the iterative WIDTH-cycle path described above.

Test Plan:
- Reset mid-division: DIVU issued, resetn=0 at cycle 10 -> hi=0, lo=0, stall=0, state IDLE next cycle.
- DIVU 100/7: srca=100, srcb=7 -> stall 33 cycles, then done=1, lo=14, hi=2. Repeated start during DONE is ignored.
- DIV signed: srca=-7 (0xFFFFFFF9), srcb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide by zero: DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234 after full latency.
- MULT -3*5 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1. MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE. Run both with and without MDU_FAST_MUL_EN, checking stall cycle counts of 33 and 0.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A back-to-back -> no stall, hi/lo updated on successive edges. Flush at RUN cycle 5 of a DIVU -> hi/lo keep the MTHI/MTLO values, no done pulse.
